rho_slice_rotator: RTL and testbench



---
 rtl/rho_slice_rotator.sv | 112 +++++++++++
 tb/tb_rho_slice_rotator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rho_slice_rotator.sv
// Buffers one serially delivered 1600-bit Keccak state and replays it slice by slice
// with the rho lane rotation applied: out_slice[24-k] = lane_k[(z - r_k) mod 64].
module rho_slice_rotator (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_slice,
    output logic        out_last,
    output logic        done
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [5:0] ROT [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    state_t      state_q, state_d;
    logic [4:0]  bc_q, bc_d;
    logic [5:0]  sc_q, sc_d;
    logic [5:0]  z_q, z_d;
    logic        done_q, done_d;
    logic [63:0] lane_q [25];
    logic [24:0] rot_slice;
    logic        in_accept;

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EMIT);
    assign in_accept = in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_d = state_q;
        bc_d    = bc_q;
        sc_d    = sc_q;
        z_d     = z_q;
        done_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (bc_q == 5'd24) begin
                        bc_d = 5'd0;
                        if (sc_q == 6'd63) begin
                            state_d = EMIT;
                            sc_d    = 6'd0;
                            z_d     = 6'd0;
                        end else begin
                            sc_d = sc_q + 6'd1;
                        end
                    end else begin
                        bc_d = bc_q + 5'd1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    z_d = z_q + 6'd1;
                    if (z_q == 6'd63) begin
                        state_d = LOAD;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            bc_q    <= 5'd0;
            sc_q    <= 6'd0;
            z_q     <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            sc_q    <= sc_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the state buffer is deliberately not reset; each bit is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            lane_q[bc_q][sc_q] <= in_bit;
        end
    end

    // The 6-bit subtraction wraps modulo 64, giving the cyclic lane rotation for free.
    for (genvar k = 0; k < 25; k++) begin : g_lane
        assign rot_slice[24-k] = lane_q[k][z_q - ROT[k]];
    end

    assign out_slice = out_valid ? rot_slice : 25'd0;
    assign out_last  = out_valid && (z_q == 6'd63);
    assign done      = done_q;

endmodule

// File: tb/tb_rho_slice_rotator.sv
// Directed bench for rho_slice_rotator: a forward-scatter rotation model plus a per-cycle
// compare process, with literal expectations on key slices.
module tb_rho_slice_rotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic        out_last;
    logic        done;

    rho_slice_rotator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned r_off [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    bit   [63:0] pat       [25];
    logic [24:0] exp_slice [64];
    logic [24:0] got_slice [64];
    logic [24:0] got_ref   [64];

    int n_checks = 0;
    int n_errors = 0;
    int hs_total = 0;
    int done_total = 0;
    logic [5:0] z_model = 6'd0;
    logic       done_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic clear_pat();
        for (int k = 0; k < 25; k++) pat[k] = 64'd0;
    endtask

    // Forward model: input bit (lane k, slice z) lands in output slice z + r_k, bit 24-k.
    task automatic build_exp();
        for (int z = 0; z < 64; z++) exp_slice[z] = 25'd0;
        for (int k = 0; k < 25; k++)
            for (int z = 0; z < 64; z++)
                if (pat[k][z]) exp_slice[(z + r_off[k]) % 64][24-k] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            z_model  = 6'd0;
            done_exp = 1'b0;
        end else begin
            check("done", done, done_exp);
            if (done) done_total++;
            done_exp = 1'b0;
            if (out_valid) begin
                check("in_ready_emit", in_ready, 0);
                check("slice", out_slice, exp_slice[z_model]);
                check("last", out_last, z_model == 6'd63);
                got_slice[z_model] = out_slice;
                if (out_ready) begin
                    hs_total++;
                    if (z_model == 6'd63) done_exp = 1'b1;
                    z_model = z_model + 6'd1;
                end
            end else begin
                check("idle_slice", out_slice, 0);
                check("idle_last", out_last, 0);
            end
        end
    end

    task automatic run_load(input bit gaps, input bit hold_valid, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int z;
            int k;
            z = i / 25;
            k = i % 25;
            if (gaps) begin
                in_valid = 1'b0;
                in_bit   = ~pat[k][z];
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_bit   = pat[k][z];
            check("in_ready_load", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = hold_valid;
        in_bit   = 1'b1;
        if (nbits == 1600) check("latency", out_valid, 1);
    endtask

    task automatic run_emit(input int stall_at, input int stall_len);
        int start_hs;
        int start_done;
        int cyc;
        int left;
        start_hs   = hs_total;
        start_done = done_total;
        cyc        = 0;
        left       = stall_len;
        while ((hs_total - start_hs) < 64 && cyc < 400) begin
            if ((hs_total - start_hs) == stall_at && left > 0) begin
                out_ready = 1'b0;
                left--;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 400) check("emit_timeout", cyc, 64 + stall_len);
        check("emit_cycles", cyc, 64 + stall_len);
        check("handshakes", hs_total - start_hs, 64);
        @(posedge clk); #1;
        check("done_pulses", done_total - start_done, 1);
        check("ready_after_done", in_ready, 1);
    endtask

    task automatic one_state(input bit gaps, input bit hold_valid, input int stall_at,
                             input int stall_len);
        build_exp();
        run_load(gaps, hold_valid, 1600);
        run_emit(stall_at, stall_len);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_slice", out_slice, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        int diffs;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        clear_pat();
        build_exp();
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Single lane-0 bit.
        clear_pat();
        pat[0][0] = 1'b1;
        one_state(1'b0, 1'b0, -1, 0);
        check("t1_slice0", got_slice[0], 25'h1000000);
        check("t1_slice1", got_slice[1], 25'h0000000);

        // Rotation by one.
        clear_pat();
        pat[1][0] = 1'b1;
        one_state(1'b0, 1'b0, -1, 0);
        check("t2_slice1", got_slice[1], 25'h0800000);
        check("t2_slice0", got_slice[0], 25'h0000000);

        // Wrap-around: 5 + 62 mod 64 = 3.
        clear_pat();
        pat[2][5] = 1'b1;
        one_state(1'b0, 1'b0, -1, 0);
        check("t3_slice3", got_slice[3], 25'h0400000);
        check("t3_slice5", got_slice[5], 25'h0000000);

        // Backpressure on slice 10 with all-ones data.
        for (int k = 0; k < 25; k++) pat[k] = '1;
        one_state(1'b0, 1'b0, 10, 3);
        check("t4_slice10", got_slice[10], 25'h1FFFFFF);

        // Gap-free reference versus gapped load with in_valid held high in EMIT.
        for (int k = 0; k < 25; k++) pat[k] = {$urandom, $urandom};
        one_state(1'b0, 1'b0, -1, 0);
        for (int z = 0; z < 64; z++) got_ref[z] = got_slice[z];
        one_state(1'b1, 1'b1, -1, 0);
        diffs = 0;
        for (int z = 0; z < 64; z++) if (got_slice[z] !== got_ref[z]) diffs++;
        check("t5_gap_vs_nogap", diffs, 0);

        // Reset after 800 bits of random data, then a clean state.
        for (int k = 0; k < 25; k++) pat[k] = {$urandom, $urandom};
        build_exp();
        run_load(1'b0, 1'b0, 800);
        rst = 1'b0;
        #3;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_pat();
        pat[24][63] = 1'b1;
        one_state(1'b0, 1'b0, -1, 0);
        check("t6_slice13", got_slice[13], 25'h0000001);
        check("t6_slice63", got_slice[63], 25'h0000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
